// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for one 8-way decoded resource: 8 requesters, bounded hold time
// per grant and one dead cycle between grants. Every output is registered.
module rr_dec_arbiter #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic [7:0] iReq,
   input  logic       iDone,
   output logic [2:0] oSel,
   output logic [1:0] oEna,
   output logic [7:0] oGrant_n,
   output logic       oBusy,
   output logic       oTimeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [1:0]       ENA_ON   = 2'b10;
   localparam logic [1:0]       ENA_OFF  = 2'b00;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state, stateNxt;
   logic [2:0]       ptr, ptrNxt;
   logic [CNT_W-1:0] cnt, cntNxt;
   logic [2:0]       selNxt;
   logic [1:0]       enaNxt;
   logic [7:0]       grantNxt_n;
   logic             busyNxt;
   logic             timeoutNxt;

   logic [2:0]       winner;
   logic             anyReq;
   logic             ownerReq;
   logic             holdHit;
   logic             exitGrant;

   // Scan upward from last+1 with wrap; last itself is visited last, so the
   // previous owner only wins when nobody else is asking.
   function automatic logic [2:0] pickNext(input logic [7:0] req, input logic [2:0] last);
      logic [2:0] cand;
      logic       found;
      pickNext = last;
      found    = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cand = last + 3'(i);
         if (req[cand] && !found) begin
            pickNext = cand;
            found    = 1'b1;
         end
      end
   endfunction

   // oSel holds the current owner's index for the whole grant.
   assign winner    = pickNext(iReq, ptr);
   assign anyReq    = |iReq;
   assign ownerReq  = iReq[oSel];
   assign holdHit   = (cnt == CNT_LAST);
   assign exitGrant = !ownerReq || iDone || holdHit;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      stateNxt   = state;
      ptrNxt     = ptr;
      cntNxt     = cnt;
      selNxt     = oSel;
      enaNxt     = ENA_OFF;
      grantNxt_n = 8'hFF;
      busyNxt    = 1'b0;
      timeoutNxt = 1'b0;

      case (state)
         IDLE, RELEASE: begin
            if (anyReq) begin
               stateNxt   = GRANT;
               selNxt     = winner;
               cntNxt     = '0;
               enaNxt     = ENA_ON;
               grantNxt_n = ~(8'h01 << winner);
               busyNxt    = 1'b1;
            end else begin
               stateNxt   = IDLE;
            end
         end

         GRANT: begin
            if (exitGrant) begin
               stateNxt   = RELEASE;
               ptrNxt     = oSel;
               cntNxt     = '0;
               // A drop or iDone takes precedence, so the limit only counts when the owner still wants it.
               timeoutNxt = holdHit && ownerReq && !iDone;
            end else begin
               cntNxt     = cnt + 1'b1;
               enaNxt     = ENA_ON;
               grantNxt_n = oGrant_n;
               busyNxt    = 1'b1;
            end
         end

         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state    <= IDLE;
         ptr      <= 3'd7;
         cnt      <= '0;
         oSel     <= 3'd0;
         oEna     <= ENA_OFF;
         oGrant_n <= 8'hFF;
         oBusy    <= 1'b0;
         oTimeout <= 1'b0;
      end else begin
         state    <= stateNxt;
         ptr      <= ptrNxt;
         cnt      <= cntNxt;
         oSel     <= selNxt;
         oEna     <= enaNxt;
         oGrant_n <= grantNxt_n;
         oBusy    <= busyNxt;
         oTimeout <= timeoutNxt;
      end
   end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: three instances (HOLD_MAX 16, 4, 1) share stimulus
// and are each compared every cycle against an owner/turn-level reference model.
module tb_rr_dec_arbiter;

   localparam int N = 3;

   logic       iClk   = 1'b0;
   logic       iRst_n = 1'b0;
   logic [7:0] iReq   = 8'h00;
   logic       iDone  = 1'b0;

   logic [2:0] sel     [N];
   logic [1:0] ena     [N];
   logic [7:0] grant_n [N];
   logic       busy    [N];
   logic       tmo     [N];

   rr_dec_arbiter #(.HOLD_MAX(16), .CNT_W(8)) u0 (
      .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iDone(iDone),
      .oSel(sel[0]), .oEna(ena[0]), .oGrant_n(grant_n[0]), .oBusy(busy[0]), .oTimeout(tmo[0]));
   rr_dec_arbiter #(.HOLD_MAX(4), .CNT_W(8)) u1 (
      .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iDone(iDone),
      .oSel(sel[1]), .oEna(ena[1]), .oGrant_n(grant_n[1]), .oBusy(busy[1]), .oTimeout(tmo[1]));
   rr_dec_arbiter #(.HOLD_MAX(1), .CNT_W(8)) u2 (
      .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iDone(iDone),
      .oSel(sel[2]), .oEna(ena[2]), .oGrant_n(grant_n[2]), .oBusy(busy[2]), .oTimeout(tmo[2]));

   always #5 iClk = ~iClk;

   int nCompared   = 0;
   int nMismatched = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: who owns the resource, how many cycles it has held it,
   // who owned it last, and what the select lines last pointed at.
   int mOwner [N];
   int mLast  [N];
   int mHeld  [N];
   int mSel   [N];
   bit mTo    [N];

   function automatic int holdOf(input int k);
      case (k)
         0:       return 16;
         1:       return 4;
         default: return 1;
      endcase
   endfunction

   function automatic int winnerOf(input logic [7:0] req, input int last);
      for (int k = 1; k <= 8; k++) begin
         if (req[(last + k) % 8]) return (last + k) % 8;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < N; k++) begin
         mOwner[k] = -1;
         mLast[k]  = 7;
         mHeld[k]  = 0;
         mSel[k]   = 0;
         mTo[k]    = 1'b0;
      end
   endtask

   task automatic modelStep(input logic [7:0] req, input logic done);
      int o;
      int w;
      for (int k = 0; k < N; k++) begin
         mTo[k] = 1'b0;
         if (mOwner[k] >= 0) begin
            o = mOwner[k];
            if (!req[o] || done || (mHeld[k] + 1 == holdOf(k))) begin
               mTo[k]    = req[o] && !done && (mHeld[k] + 1 == holdOf(k));
               mLast[k]  = o;
               mOwner[k] = -1;
               mHeld[k]  = 0;
            end else begin
               mHeld[k]++;
            end
         end else begin
            w = winnerOf(req, mLast[k]);
            if (w >= 0) begin
               mOwner[k] = w;
               mSel[k]   = w;
               mHeld[k]  = 0;
            end
         end
      end
   endtask

   task automatic compareAll();
      logic [7:0] g;
      bit         on;
      for (int k = 0; k < N; k++) begin
         on = (mOwner[k] >= 0);
         g  = 8'hFF;
         if (on) g[mOwner[k]] = 1'b0;
         check($sformatf("i%0d oSel", k),     32'(sel[k]),     32'(mSel[k]));
         check($sformatf("i%0d oEna", k),     32'(ena[k]),     on ? 32'h2 : 32'h0);
         check($sformatf("i%0d oGrant_n", k), 32'(grant_n[k]), 32'(g));
         check($sformatf("i%0d oBusy", k),    32'(busy[k]),    32'(on));
         check($sformatf("i%0d oTimeout", k), 32'(tmo[k]),     32'(mTo[k]));
      end
   endtask

   // Inputs change at the falling edge; outputs are compared at the next falling edge.
   task automatic cycle(input logic [7:0] req, input logic done);
      iReq  = req;
      iDone = done;
      @(posedge iClk);
      modelStep(req, done);
      @(negedge iClk);
      compareAll();
   endtask

   task automatic doReset();
      iRst_n = 1'b0;
      iReq   = 8'h00;
      iDone  = 1'b0;
      modelReset();
      @(negedge iClk);
      iRst_n = 1'b1;
      compareAll();
   endtask

   int         nTo;
   logic [7:0] rq;
   logic       dn;

   initial begin
      modelReset();
      repeat (2) @(negedge iClk);
      compareAll();
      iRst_n = 1'b1;

      // Single requester: grant on the first edge, then release and idle.
      cycle(8'h08, 1'b0);
      check("t2 sel", 32'(sel[0]), 32'd3);
      check("t2 ena", 32'(ena[0]), 32'h2);
      check("t2 grant_n", 32'(grant_n[0]), 32'hF7);
      cycle(8'h00, 1'b0);
      check("t2 release grant_n", 32'(grant_n[0]), 32'hFF);
      cycle(8'h00, 1'b0);
      check("t2 idle busy", 32'(busy[0]), 32'd0);

      // Wrap-around: after owner 6, requesters 0 and 6 are served 0 first.
      cycle(8'h40, 1'b0);
      check("t4 sel6", 32'(sel[0]), 32'd6);
      cycle(8'h00, 1'b0);
      cycle(8'h41, 1'b0);
      check("t4 first sel0", 32'(sel[0]), 32'd0);
      cycle(8'h40, 1'b0);
      cycle(8'h40, 1'b0);
      check("t4 then sel6", 32'(sel[0]), 32'd6);

      // iDone and request drop together while cnt=2.
      doReset();
      repeat (3) cycle(8'h03, 1'b0);
      cycle(8'h02, 1'b1);
      check("t5 timeout", 32'(tmo[0]), 32'd0);
      check("t5 dead grant_n", 32'(grant_n[0]), 32'hFF);
      cycle(8'h02, 1'b0);
      check("t5 next sel", 32'(sel[0]), 32'd1);

      // All requesting with HOLD_MAX=4: a timeout every 5 cycles.
      doReset();
      nTo = 0;
      for (int i = 0; i < 45; i++) begin
         cycle(8'hFF, 1'b0);
         if (tmo[1]) nTo++;
      end
      check("t3 timeout count", 32'(nTo), 32'd9);

      // HOLD_MAX=1 alternating between 0 and 7.
      doReset();
      repeat (20) cycle(8'h81, 1'b0);

      // Asynchronous reset in the middle of a grant.
      doReset();
      cycle(8'h08, 1'b0);
      check("t1 pre busy", 32'(busy[0]), 32'd1);
      #2;
      iRst_n = 1'b0;
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("t1 i%0d grant_n", k), 32'(grant_n[k]), 32'hFF);
         check($sformatf("t1 i%0d ena", k),     32'(ena[k]),     32'h0);
         check($sformatf("t1 i%0d sel", k),     32'(sel[k]),     32'h0);
         check($sformatf("t1 i%0d busy", k),    32'(busy[k]),    32'h0);
      end
      modelReset();
      iReq = 8'h00;
      @(negedge iClk);
      iRst_n = 1'b1;
      compareAll();

      // Randomized traffic: requests held for stretches, occasional iDone pulses.
      rq = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       rq = 8'h00;
               1:       rq = 8'h01 << $urandom_range(0, 7);
               default: rq = 8'($urandom);
            endcase
         end
         dn = ($urandom_range(0, 15) == 0);
         cycle(rq, dn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
